serial_adder_16bit: RTL and testbench

Bit-serial two's-complement adder/subtractor for the datapath's area-reduced arithmetic path. It computes one result bit per clock through a single `full_adder_1bit` cell and a registered carry, so a W-bit add or subtract takes W cycles. It sits directly downstream of the full-adder cell: it sequences operands into the cell, captures the cell's sum and carry each cycle, and presents a registered result with flags to the consuming execute logic via a start/done handshake.

---
 rtl/serial_adder_16bit.sv | 90 +++++++++
 tb/tb_serial_adder_16bit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_16bit.sv
// serial_adder_16bit: bit-serial W-bit two's-complement add/subtract, one result bit per clock
// through a single full-adder cell, with start/done handshake and registered result flags.
module serial_adder_16bit #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_sub,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_sum,
  output logic         o_cout,
  output logic         o_ovfl,
  output logic         o_zero
);
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        r_state, w_next;
  logic [W-1:0]  r_opa, r_opb, r_res, w_res;
  logic [CW-1:0] r_cnt;
  logic          r_carry, r_cmsb, w_s, w_co, w_accept, w_last;
  full_adder_1bit u_fa (
    .i_a   (r_opa[0]),
    .i_b   (r_opb[0]),
    .i_cin (r_carry),
    .o_sum (w_s),
    .o_cout(w_co)
  );
  always_comb begin
    w_accept = i_start && (r_state != RUN);
    w_last   = (r_state == RUN) && (r_cnt == CW'(W-1));
    w_res    = {w_s, r_res[W-1:1]};
    w_next   = (r_state == RUN) ? (w_last ? DONE : RUN) : (i_start ? RUN : IDLE);
  end
  assign o_busy = (r_state == RUN);
  assign o_done = (r_state == DONE);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cmsb  <= 1'b0;
      o_sum   <= '0;
      o_cout  <= 1'b0;
      o_ovfl  <= 1'b0;
      o_zero  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_opa   <= i_a;
        r_opb   <= i_sub ? ~i_b : i_b;
        r_carry <= i_sub;
        r_cnt   <= '0;
        r_res   <= '0;
      end else if (r_state == RUN) begin
        r_opa   <= r_opa >> 1;
        r_opb   <= r_opb >> 1;
        r_carry <= w_co;
        r_cnt   <= r_cnt + CW'(1);
        r_res   <= w_res;
        // carry into the MSB; XOR with carry out of the MSB gives signed overflow
        if (r_cnt == CW'(W-2))
          r_cmsb <= w_co;
        if (w_last) begin
          o_sum  <= w_res;
          o_cout <= w_co;
          o_ovfl <= r_cmsb ^ w_co;
          o_zero <= (w_res == '0);
        end
      end
    end
  end
endmodule

module full_adder_1bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// File: tb/tb_serial_adder_16bit.sv
// tb_serial_adder_16bit: randomized and directed checks of the serial adder against an integer model.
module tb_serial_adder_16bit;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, cout, ovfl, zero;
  logic [15:0] sum;
  int          total = 0, bad = 0;

  serial_adder_16bit #(.W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_sub(sub), .i_a(a), .i_b(b),
    .o_busy(busy), .o_done(done), .o_sum(sum), .o_cout(cout), .o_ovfl(ovfl), .o_zero(zero)
  );

  always #5 clk = ~clk;

  // expected {sum, cout, ovfl, zero} from plain integer arithmetic
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
    int ua = int'(x), ub = int'(y), sa = int'($signed(x)), sb = int'($signed(y)), t, r;
    logic [15:0] sm;
    logic c, v;
    t  = s ? ua - ub : ua + ub;
    sm = t[15:0];
    c  = s ? (ua >= ub) : (t > 65535);
    r  = s ? sa - sb : sa + sb;
    v  = (r > 32767) || (r < -32768);
    return {sm, c, v, sm == 16'h0000};
  endfunction

  // entered just after an edge with the DUT idle or in its done cycle; returns in the done cycle
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                        output int lat, output logic [18:0] res, output logic bz);
    a = x; b = y; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    res = {sum, cout, ovfl, zero};
    bz  = busy;
  endtask

  task automatic test_reset();
    logic [18:0] res;
    int lat;
    logic bz, quiet;
    repeat (2) @(posedge clk);
    #1;
    if ({busy, done, sum, cout, ovfl, zero} !== 20'h0) begin
      bad++; $display("FAIL reset_state got=%h want=0", {busy, done, sum, cout, ovfl, zero});
    end
    total++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'hFFFF, 16'h0001, 1'b0, lat, res, bz);
    #2 rst_n = 1'b0;
    #1;
    if ({busy, done, sum, cout, ovfl, zero} !== 20'h0) begin
      bad++; $display("FAIL async_reset got=%h want=0", {busy, done, sum, cout, ovfl, zero});
    end
    total++;
    #1 rst_n = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (busy || done) quiet = 1'b0;
    end
    if (quiet !== 1'b1) begin
      bad++; $display("FAIL idle_quiet got busy/done activity want none");
    end
    total++;
  endtask

  task automatic test_basic();
    logic [18:0] res;
    int lat;
    logic bz;
    run_op(16'h1234, 16'h4321, 1'b0, lat, res, bz);
    if (lat !== 16) begin bad++; $display("FAIL basic_latency got=%0d want=16", lat); end
    total++;
    if (bz !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b want=0", bz); end
    total++;
    if (res !== {16'h5555, 3'b000}) begin
      bad++; $display("FAIL basic_result got=%h want=%h", res, {16'h5555, 3'b000});
    end
    total++;
  endtask

  task automatic test_boundaries();
    logic [15:0] xa [5] = '{16'h7FFF, 16'hFFFF, 16'h0005, 16'h8000, 16'h0003};
    logic [15:0] xb [5] = '{16'h0001, 16'h0001, 16'h0005, 16'h0001, 16'h0004};
    logic        xs [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [18:0] want [5] = '{{16'h8000, 3'b010}, {16'h0000, 3'b101}, {16'h0000, 3'b101},
                              {16'h7FFF, 3'b110}, {16'hFFFF, 3'b000}};
    logic [18:0] res;
    int lat;
    logic bz;
    for (int i = 0; i < 5; i++) begin
      run_op(xa[i], xb[i], xs[i], lat, res, bz);
      if (res !== want[i] || lat !== 16) begin
        bad++; $display("FAIL boundary_%0d got=%h lat=%0d want=%h lat=16", i, res, lat, want[i]);
      end
      total++;
    end
  endtask

  task automatic test_random();
    logic [15:0] x, y;
    logic s, bz;
    logic [18:0] res;
    int lat;
    for (int i = 0; i < 40; i++) begin
      x = 16'($urandom); y = 16'($urandom); s = 1'($urandom);
      run_op(x, y, s, lat, res, bz);
      if (res !== model(x, y, s) || lat !== 16) begin
        bad++; $display("FAIL random_%0d %h %s %h got=%h lat=%0d want=%h", i, x, s ? "-" : "+", y, res, lat, model(x, y, s));
      end
      total++;
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      start = (n == 5);
      if (n == 5) begin a = 16'hFFFF; b = 16'h0F0F; sub = 1'b1; end
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    start = 1'b0;
    if (lat !== 16 || {sum, cout, ovfl, zero} !== {16'h3333, 3'b000}) begin
      bad++; $display("FAIL ignore_start got=%h lat=%0d want=%h lat=16", {sum, cout, ovfl, zero}, lat, {16'h3333, 3'b000});
    end
    total++;
  endtask

  task automatic test_back_to_back();
    logic [18:0] first, res;
    int lat, gap;
    logic bz, held;
    run_op(16'h0F0F, 16'h00F1, 1'b0, lat, first, bz);
    a = 16'h0002; b = 16'h0007; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_no_gap got busy=%b want=1", busy); end
    total++;
    held = 1'b1;
    gap  = -1;
    for (int n = 2; n <= 40; n++) begin
      if ({sum, cout, ovfl, zero} !== first) held = 1'b0;
      @(posedge clk); #1;
      if (done) begin gap = n; break; end
    end
    if (held !== 1'b1) begin bad++; $display("FAIL b2b_hold got changed outputs want=%h", first); end
    total++;
    if (gap !== 17) begin bad++; $display("FAIL b2b_spacing got=%0d want=17", gap); end
    total++;
    res = {sum, cout, ovfl, zero};
    if (res !== model(16'h0002, 16'h0007, 1'b1)) begin
      bad++; $display("FAIL b2b_result got=%h want=%h", res, model(16'h0002, 16'h0007, 1'b1));
    end
    total++;
  endtask

  task automatic test_reset_mid();
    logic [18:0] res;
    int lat;
    logic bz, quiet;
    run_op(16'h1234, 16'h4321, 1'b0, lat, res, bz);
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    if ({busy, done, sum, cout, ovfl, zero} !== 20'h0) begin
      bad++; $display("FAIL midop_reset got=%h want=0", {busy, done, sum, cout, ovfl, zero});
    end
    total++;
    #1 rst_n = 1'b1;
    quiet = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy) quiet = 1'b0;
    end
    if (quiet !== 1'b1) begin bad++; $display("FAIL midop_no_done got activity want none"); end
    total++;
    run_op(16'h00FF, 16'h0F01, 1'b0, lat, res, bz);
    if (res !== {16'h1000, 3'b000} || lat !== 16) begin
      bad++; $display("FAIL after_reset got=%h lat=%0d want=%h lat=16", res, lat, {16'h1000, 3'b000});
    end
    total++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
